// File: rtl/mux_n_1_scan.sv
// mux_n_1_scan: registered N:1 multiplexer of W-bit channels with a manual
// select mode and an optional auto-scan mode (round-robin, DWELL cycles per
// channel). Every output is a flop; there is no combinational input-to-output
// path.
//
// Build option: define MUX_SCAN_EN to include the scan mode. Without it the
// SCAN state, scan pointer and dwell counter are not built, mode is ignored
// (an enabled edge always behaves as manual) and DWELL is unused.
//
// Ports:
//   clk      clock, all outputs update on the rising edge
//   rst_n    synchronous active-low reset, priority over all other inputs
//   in_bus   N*W channel data, channel k at in_bus[k*W +: W]
//   sel      manual channel select
//   mode     0 = manual, 1 = scan
//   en       enable; low forces the idle state
//   y        registered selected channel data
//   y_valid  y was updated on the last edge
//   cur_sel  index of the channel that produced y
//   err      last edge was a manual edge with sel >= N
module mux_n_1_scan #(
    parameter int N     = 4,
    parameter int W     = 8,
    parameter int DWELL = 4,
    localparam int SELW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N*W-1:0]  in_bus,
    input  logic [SELW-1:0] sel,
    input  logic            mode,
    input  logic            en,
    output logic [W-1:0]    y,
    output logic            y_valid,
    output logic [SELW-1:0] cur_sel,
    output logic            err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t          state;
    logic [W-1:0]    y_p1;
    logic            vld_p1;
    logic [SELW-1:0] cur_sel_p1;
    logic            err_p1;

    logic [W-1:0] chan [N];
    logic         sel_ok;
    logic         scan_req;

    for (genvar k = 0; k < N; k++) begin : g_chan
        assign chan[k] = in_bus[k*W +: W];
    end

    assign sel_ok = (int'(sel) < N);

`ifdef MUX_SCAN_EN
    logic [SELW-1:0] p;
    logic [7:0]      cnt;
    logic [SELW-1:0] scan_idx;
    logic [7:0]      cnt_eff;

    assign scan_req = mode;
    // A scan edge that follows any non-scan edge always starts from channel 0
    // with a fresh dwell count, regardless of what p/cnt hold.
    assign scan_idx = (state == SCAN) ? p   : '0;
    assign cnt_eff  = (state == SCAN) ? cnt : 8'd0;
`else
    logic mode_unused;

    assign scan_req    = 1'b0;
    assign mode_unused = ^{mode, state};
`endif

    // ---- stage p0 -> p1: input sample to registered outputs ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            y_p1       <= '0;
            vld_p1     <= 1'b0;
            cur_sel_p1 <= '0;
            err_p1     <= 1'b0;
`ifdef MUX_SCAN_EN
            p          <= '0;
            cnt        <= 8'd0;
`endif
        end else if (!en) begin
            state  <= IDLE;
            vld_p1 <= 1'b0;
            err_p1 <= 1'b0;
`ifdef MUX_SCAN_EN
            p      <= '0;
            cnt    <= 8'd0;
`endif
        end else if (!scan_req) begin
            state <= MANUAL;
`ifdef MUX_SCAN_EN
            p     <= '0;
            cnt   <= 8'd0;
`endif
            if (sel_ok) begin
                y_p1       <= chan[sel];
                cur_sel_p1 <= sel;
                vld_p1     <= 1'b1;
                err_p1     <= 1'b0;
            end else begin
                // Out-of-range select: keep the last good data and flag it.
                vld_p1 <= 1'b0;
                err_p1 <= 1'b1;
            end
        end
`ifdef MUX_SCAN_EN
        else begin
            state      <= SCAN;
            y_p1       <= chan[scan_idx];
            cur_sel_p1 <= scan_idx;
            vld_p1     <= 1'b1;
            err_p1     <= 1'b0;
            if (cnt_eff == 8'(DWELL - 1)) begin
                cnt <= 8'd0;
                // Explicit wrap so non-power-of-two N never reaches index N.
                p   <= (scan_idx == SELW'(N - 1)) ? '0 : scan_idx + 1'b1;
            end else begin
                cnt <= cnt_eff + 8'd1;
                p   <= scan_idx;
            end
        end
`endif
    end

    assign y       = y_p1;
    assign y_valid = vld_p1;
    assign cur_sel = cur_sel_p1;
    assign err     = err_p1;

endmodule
